// File: rtl/ray_dispatch_scheduler.sv
// Frame-level ray dispatch scheduler.
// Walks the screen in raster order, hands one pixel per cycle to an idle
// ray-marcher core (round-robin), and serialises the finished colours onto
// the single framebuffer write port (independent round-robin).
//
// Handshake: core_ready_in is sampled in the decision cycle; the grant appears
// one cycle later as a one-hot, single-cycle core_valid_out with the pixel
// coordinates alongside. A core holds core_done_in with its colour until it
// sees its one-cycle core_ack_out, which is registered alongside the
// framebuffer write it produced. A core is owned from its issue until the
// edge that registers its ack, and is never re-issued while owned.
//
// state_out encoding: 0 IDLE, 1 DISPATCH, 2 DRAIN, 3 DONE.
module ray_dispatch_scheduler #(
   parameter int NUM_CORES   = 4,
   parameter int H_RES       = 320,
   parameter int V_RES       = 240,
   parameter int ADDR_WIDTH  = 17,
   parameter int COLOR_WIDTH = 12
) (
   input  logic                             clk_in,
   input  logic                             rst_in,
   input  logic                             start_in,
   input  logic [NUM_CORES-1:0]             core_ready_in,
   output logic [NUM_CORES-1:0]             core_valid_out,
   output logic [8:0]                       core_hcount_out,
   output logic [7:0]                       core_vcount_out,
   input  logic [NUM_CORES-1:0]             core_done_in,
   input  logic [NUM_CORES*COLOR_WIDTH-1:0] core_color_in,
   output logic [NUM_CORES-1:0]             core_ack_out,
   output logic                             fb_we_out,
   output logic [ADDR_WIDTH-1:0]            fb_addr_out,
   output logic [COLOR_WIDTH-1:0]           fb_data_out,
   output logic                             busy_out,
   output logic                             frame_done_out,
   output logic [1:0]                       state_out
);

   localparam int               PTR_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam logic [8:0]       H_LAST   = 9'(H_RES - 1);
   localparam logic [7:0]       V_LAST   = 8'(V_RES - 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_CORES - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_DISPATCH = 2'd1,
      S_DRAIN    = 2'd2,
      S_DONE     = 2'd3
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [8:0]            hcount_q;
   logic [7:0]            vcount_q;
   logic [NUM_CORES-1:0]  owned_q;
   logic [PTR_W-1:0]      issue_ptr_q;
   logic [PTR_W-1:0]      write_ptr_q;
   logic [ADDR_WIDTH-1:0] addr_reg_q [NUM_CORES];

   logic [NUM_CORES-1:0]  eligible;
   logic                  issue_fire;
   logic [PTR_W-1:0]      issue_idx;
   logic [NUM_CORES-1:0]  issue_onehot;
   logic [PTR_W-1:0]      issue_scan;

   logic [NUM_CORES-1:0]  candidate;
   logic                  write_fire;
   logic [PTR_W-1:0]      write_idx;
   logic [NUM_CORES-1:0]  write_onehot;
   logic [PTR_W-1:0]      write_scan;

   logic                  last_pixel;
   logic [ADDR_WIDTH-1:0] addr_calc;

   // Wrap a core pointer to the next core, modulo NUM_CORES.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   assign last_pixel = (hcount_q == H_LAST) && (vcount_q == V_LAST);
   assign addr_calc  = ADDR_WIDTH'(int'(vcount_q) * H_RES + int'(hcount_q));
   assign state_out  = state_q;

   // Issue arbiter: first ready, unowned core at or after the issue pointer.
   always_comb begin
      eligible     = core_ready_in & ~owned_q;
      issue_fire   = 1'b0;
      issue_idx    = '0;
      issue_onehot = '0;
      issue_scan   = '0;
      if (state_q == S_DISPATCH) begin
         for (int k = 0; k < NUM_CORES; k++) begin
            if (int'(issue_ptr_q) + k >= NUM_CORES)
               issue_scan = PTR_W'(int'(issue_ptr_q) + k - NUM_CORES);
            else
               issue_scan = PTR_W'(int'(issue_ptr_q) + k);
            if (!issue_fire && eligible[issue_scan]) begin
               issue_fire = 1'b1;
               issue_idx  = issue_scan;
            end
         end
         issue_onehot[issue_idx] = issue_fire;
      end
   end

   // Write arbiter: owned cores holding a result, excluding the one acked this cycle.
   always_comb begin
      candidate    = core_done_in & owned_q & ~core_ack_out;
      write_fire   = 1'b0;
      write_idx    = '0;
      write_onehot = '0;
      write_scan   = '0;
      if ((state_q == S_DISPATCH) || (state_q == S_DRAIN)) begin
         for (int k = 0; k < NUM_CORES; k++) begin
            if (int'(write_ptr_q) + k >= NUM_CORES)
               write_scan = PTR_W'(int'(write_ptr_q) + k - NUM_CORES);
            else
               write_scan = PTR_W'(int'(write_ptr_q) + k);
            if (!write_fire && candidate[write_scan]) begin
               write_fire = 1'b1;
               write_idx  = write_scan;
            end
         end
         write_onehot[write_idx] = write_fire;
      end
   end

   // Frame state register.
   always_ff @(posedge clk_in) begin
      if (rst_in) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic and state-derived status outputs.
   always_comb begin
      state_d        = state_q;
      busy_out       = 1'b0;
      frame_done_out = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_in) state_d = S_DISPATCH;
         end
         S_DISPATCH: begin
            busy_out = 1'b1;
            if (issue_fire && last_pixel) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            busy_out = 1'b1;
            // A write registered this cycle still counts as in flight.
            if ((owned_q == '0) && !fb_we_out) state_d = S_DONE;
         end
         S_DONE: begin
            frame_done_out = 1'b1;
            state_d        = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Raster counter, ownership, per-core addresses and registered strobes.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         hcount_q        <= '0;
         vcount_q        <= '0;
         owned_q         <= '0;
         issue_ptr_q     <= '0;
         write_ptr_q     <= '0;
         core_valid_out  <= '0;
         core_hcount_out <= '0;
         core_vcount_out <= '0;
         core_ack_out    <= '0;
         fb_we_out       <= 1'b0;
         fb_addr_out     <= '0;
         fb_data_out     <= '0;
         for (int i = 0; i < NUM_CORES; i++) addr_reg_q[i] <= '0;
      end else begin
         core_valid_out  <= issue_onehot;
         core_ack_out    <= write_onehot;
         fb_we_out       <= write_fire;
         core_hcount_out <= '0;
         core_vcount_out <= '0;
         fb_addr_out     <= '0;
         fb_data_out     <= '0;
         // Issue and write never target the same core: one needs it unowned, the other owned.
         owned_q         <= (owned_q | issue_onehot) & ~write_onehot;

         if (issue_fire) begin
            core_hcount_out       <= hcount_q;
            core_vcount_out       <= vcount_q;
            addr_reg_q[issue_idx] <= addr_calc;
            issue_ptr_q           <= ptr_inc(issue_idx);
            if (hcount_q == H_LAST) begin
               hcount_q <= '0;
               vcount_q <= (vcount_q == V_LAST) ? '0 : vcount_q + 8'd1;
            end else begin
               hcount_q <= hcount_q + 9'd1;
            end
         end

         if (write_fire) begin
            fb_addr_out <= addr_reg_q[write_idx];
            fb_data_out <= core_color_in[write_idx*COLOR_WIDTH +: COLOR_WIDTH];
            write_ptr_q <= ptr_inc(write_idx);
         end
      end
   end

endmodule

// File: tb/tb_ray_dispatch_scheduler.sv
// Bench for ray_dispatch_scheduler on a 4x2 screen with two cores.
// A cycle model built from the scheduling rules predicts every strobe; a
// simple core model returns colours after a latency; framebuffer writes are
// matched against an expected queue; per-frame totals come from a table.
module tb_ray_dispatch_scheduler;

   localparam int NC   = 2;
   localparam int HR   = 4;
   localparam int VR   = 2;
   localparam int AW   = 3;
   localparam int CW   = 12;
   localparam int NPIX = HR * VR;

   logic            clk;
   logic            rst;
   logic            start;
   logic [NC-1:0]   ready;
   logic [NC-1:0]   valid;
   logic [8:0]      hc;
   logic [7:0]      vc;
   logic [NC-1:0]   done;
   logic [NC*CW-1:0] color;
   logic [NC-1:0]   ack;
   logic            we;
   logic [AW-1:0]   addr;
   logic [CW-1:0]   data;
   logic            busy;
   logic            fdone;
   logic [1:0]      st;

   ray_dispatch_scheduler #(
      .NUM_CORES(NC), .H_RES(HR), .V_RES(VR), .ADDR_WIDTH(AW), .COLOR_WIDTH(CW)
   ) dut (
      .clk_in(clk), .rst_in(rst), .start_in(start),
      .core_ready_in(ready), .core_valid_out(valid),
      .core_hcount_out(hc), .core_vcount_out(vc),
      .core_done_in(done), .core_color_in(color), .core_ack_out(ack),
      .fb_we_out(we), .fb_addr_out(addr), .fb_data_out(data),
      .busy_out(busy), .frame_done_out(fdone), .state_out(st)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] mask;
      int         lat0;
      int         lat1;
      int         stray;
      bit         start_mid;
      bit         rnd;
      logic [1:0] allowed;
      int         exp_writes;
      bit         exp_simul;
   } scen_t;

   scen_t tbl [6];
   scen_t rnd_scen;

   int checks;
   int errors;

   // Stimulus knobs
   logic [1:0] k_mask;
   int         k_lat [NC];
   int         k_stray;
   bit         k_rand;
   bit         k_start;
   bit         k_rst;

   // Reference model (states: 0 idle, 1 dispatch, 2 drain, 3 done)
   bit         m_live;
   int         m_state;
   int         m_pix;
   int         m_iptr;
   int         m_wptr;
   logic [1:0] m_owned;
   int         m_addr [NC];
   logic [1:0] e_valid;
   logic [1:0] e_ack;
   logic       e_we;
   int         e_h;
   int         e_v;
   logic [AW+CW-1:0] exp_q[$];

   // Core model
   bit c_job [NC];
   int c_cnt [NC];
   int c_pix [NC];

   // Frame statistics
   int         f_writes;
   int         f_pulses;
   int         f_issues;
   int         f_viol;
   int         f_written [NPIX];
   bit         f_simul;
   logic [1:0] f_allowed;

   function automatic logic [CW-1:0] colf(input int p);
      return 12'(p * 291 + 165);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, 32'(valid), 0);
      chk({tag, "_ack"}, 32'(ack), 0);
      chk({tag, "_we"}, 32'(we), 0);
      chk({tag, "_hcount"}, 32'(hc), 0);
      chk({tag, "_vcount"}, 32'(vc), 0);
      chk({tag, "_addr"}, 32'(addr), 0);
      chk({tag, "_data"}, 32'(data), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_frame_done"}, 32'(fdone), 0);
      chk({tag, "_state_idle"}, 32'(st), 0);
   endtask

   // Predict next-cycle outputs from the current model state and applied inputs.
   task automatic predict(input logic [1:0] rdy, input logic [1:0] d);
      logic [1:0] n_valid, n_ack, set_o, clr_o;
      logic       n_we;
      int         n_h, n_v, idx, base;
      bit         found, last;
      n_valid = '0; n_ack = '0; set_o = '0; clr_o = '0; n_we = 1'b0;
      n_h = 0; n_v = 0; found = 0; last = 0;
      if (k_rst) begin
         m_state = 0; m_pix = 0; m_iptr = 0; m_wptr = 0; m_owned = '0;
         exp_q.delete();
         e_valid = '0; e_ack = '0; e_we = 1'b0; e_h = 0; e_v = 0;
         m_live = 1;
      end else if (m_live) begin
         if (m_state == 1) begin
            base = m_iptr;
            for (int k = 0; k < NC; k++) begin
               idx = (base + k) % NC;
               if (!found && rdy[idx] && !m_owned[idx]) begin
                  found = 1;
                  n_valid[idx] = 1'b1;
                  n_h = m_pix % HR;
                  n_v = m_pix / HR;
                  m_addr[idx] = m_pix;
                  m_iptr = (idx + 1) % NC;
                  set_o[idx] = 1'b1;
                  m_pix++;
                  if (m_pix == NPIX) begin
                     last = 1;
                     m_pix = 0;
                  end
               end
            end
         end
         if (m_state == 1 || m_state == 2) begin
            found = 0;
            base = m_wptr;
            for (int k = 0; k < NC; k++) begin
               idx = (base + k) % NC;
               if (!found && d[idx] && m_owned[idx] && !e_ack[idx]) begin
                  found = 1;
                  n_ack[idx] = 1'b1;
                  n_we = 1'b1;
                  exp_q.push_back({3'(m_addr[idx]), colf(m_addr[idx])});
                  clr_o[idx] = 1'b1;
                  m_wptr = (idx + 1) % NC;
               end
            end
         end
         case (m_state)
            0: if (k_start) m_state = 1;
            1: if (last) m_state = 2;
            2: if (m_owned == 2'b00 && !e_we) m_state = 3;
            default: m_state = 0;
         endcase
         m_owned = (m_owned | set_o) & ~clr_o;
         e_valid = n_valid; e_ack = n_ack; e_we = n_we; e_h = n_h; e_v = n_v;
      end
   endtask

   // One clock cycle, entered and left at a falling edge: check, run cores, drive, predict.
   task automatic cycle();
      logic [1:0]       clr, rdy, d;
      logic [NC*CW-1:0] col;
      logic [AW+CW-1:0] e;
      if (m_live) begin
         chk("valid", 32'(valid), 32'(e_valid));
         if (e_valid != 2'b00) begin
            chk("hcount", 32'(hc), 32'(e_h));
            chk("vcount", 32'(vc), 32'(e_v));
         end
         chk("ack", 32'(ack), 32'(e_ack));
         chk("fb_we", 32'(we), 32'(e_we));
         chk("busy", 32'(busy), 32'(m_state == 1 || m_state == 2));
         chk("frame_done", 32'(fdone), 32'(m_state == 3));
      end
      if (we === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("fb_write_expected", 32'(exp_q.size()), 1);
         end else begin
            e = exp_q.pop_front();
            chk("fb_addr", 32'(addr), 32'(e[AW+CW-1:CW]));
            chk("fb_data", 32'(data), 32'(e[CW-1:0]));
         end
         f_writes++;
         f_written[int'(addr)]++;
      end
      if (fdone === 1'b1) f_pulses++;
      if ((valid & ~f_allowed) != 2'b00) f_viol++;
      if (valid != 2'b00) f_issues++;

      for (int i = 0; i < NC; i++) begin
         clr[i] = (ack[i] === 1'b1);
         if (valid[i] === 1'b1) begin
            if (c_job[i]) f_viol++;
            c_job[i] = 1;
            c_pix[i] = int'(vc) * HR + int'(hc);
            c_cnt[i] = k_rand ? int'($urandom_range(1, 5)) : k_lat[i];
         end else if (c_job[i] && c_cnt[i] > 0) begin
            c_cnt[i]--;
         end
      end

      rdy = k_rand ? 2'($urandom_range(0, 3)) : k_mask;
      for (int i = 0; i < NC; i++) begin
         d[i] = c_job[i] && (c_cnt[i] == 0);
         if (!c_job[i]) begin
            if (k_stray == 2)      d[i] = 1'b1;
            else if (k_stray == 1) d[i] = 1'($urandom_range(0, 1));
         end
         col[i*CW +: CW] = c_job[i] ? colf(c_pix[i]) : 12'($urandom_range(0, 4095));
      end
      ready = rdy;
      done  = d;
      color = col;
      start = k_start;
      rst   = k_rst;
      if (d == 2'b11 && m_owned == 2'b11) f_simul = 1;
      predict(rdy, d);
      for (int i = 0; i < NC; i++) if (clr[i] || k_rst) c_job[i] = 0;
      @(negedge clk);
   endtask

   task automatic clear_stats(input logic [1:0] allowed);
      f_writes = 0; f_pulses = 0; f_issues = 0; f_viol = 0; f_simul = 0;
      for (int a = 0; a < NPIX; a++) f_written[a] = 0;
      f_allowed = allowed;
   endtask

   task automatic run_frame(input scen_t s);
      int n, uniq;
      clear_stats(s.allowed);
      k_mask = s.mask; k_lat[0] = s.lat0; k_lat[1] = s.lat1;
      k_stray = s.stray; k_rand = s.rnd;
      k_start = 1; cycle(); k_start = 0;
      n = 0;
      while (f_pulses == 0 && n < 400) begin
         if (s.start_mid && n == 5) k_start = 1;
         cycle();
         k_start = 0;
         n++;
      end
      if (f_pulses == 0) chk("frame_timeout", 32'(f_pulses), 1);
      repeat (3) cycle();
      uniq = 0;
      for (int a = 0; a < NPIX; a++) if (f_written[a] == 1) uniq++;
      chk("frame_writes", 32'(f_writes), 32'(s.exp_writes));
      chk("frame_done_pulses", 32'(f_pulses), 1);
      chk("frame_issues", 32'(f_issues), NPIX);
      chk("addr_once", 32'(uniq), NPIX);
      chk("valid_or_reissue_violations", 32'(f_viol), 0);
      chk("busy_after", 32'(busy), 0);
      chk("exp_q_drained", 32'(exp_q.size()), 0);
      if (s.exp_simul) chk("simultaneous_done_seen", 32'(f_simul), 1);
      k_stray = 0; k_rand = 0;
   endtask

   initial begin
      int n, n_stray;
      //           mask   l0 l1 stray mid rnd allowed writes simul
      tbl[0] = '{2'b11, 3, 3, 0, 0, 0, 2'b11, NPIX, 0};
      tbl[1] = '{2'b10, 3, 3, 0, 0, 0, 2'b10, NPIX, 0};
      tbl[2] = '{2'b11, 4, 3, 0, 0, 0, 2'b11, NPIX, 1};
      tbl[3] = '{2'b11, 2, 2, 1, 0, 0, 2'b11, NPIX, 0};
      tbl[4] = '{2'b11, 3, 3, 0, 1, 0, 2'b11, NPIX, 0};
      tbl[5] = '{2'b01, 1, 1, 0, 0, 0, 2'b01, NPIX, 0};
      rnd_scen = '{2'b11, 1, 1, 1, 0, 1, 2'b11, NPIX, 0};

      checks = 0; errors = 0;
      m_live = 0; m_state = 0; m_pix = 0; m_iptr = 0; m_wptr = 0; m_owned = '0;
      e_valid = '0; e_ack = '0; e_we = 1'b0; e_h = 0; e_v = 0;
      for (int i = 0; i < NC; i++) begin
         c_job[i] = 0; c_cnt[i] = 0; c_pix[i] = 0; k_lat[i] = 1; m_addr[i] = 0;
      end
      k_mask = '0; k_stray = 0; k_rand = 0; k_start = 0; k_rst = 1;
      clear_stats(2'b11);
      rst = 1'b1; start = 1'b0; ready = '0; done = '0; color = '0;

      @(negedge clk);
      repeat (3) cycle();
      k_rst = 0;
      chk_zero("reset");

      // Stray done while idle: nothing owned, so no write and no ack.
      k_stray = 2;
      n_stray = 0;
      repeat (6) begin
         cycle();
         if (we === 1'b1 || ack != 2'b00) n_stray++;
      end
      chk("stray_idle_writes", 32'(n_stray), 0);
      k_stray = 0;

      for (int s = 0; s < 6; s++) run_frame(tbl[s]);

      // Reset after three issues abandons the frame.
      clear_stats(2'b11);
      k_mask = 2'b11; k_lat[0] = 3; k_lat[1] = 3;
      k_start = 1; cycle(); k_start = 0;
      n = 0;
      while (f_issues < 3 && n < 50) begin
         cycle();
         n++;
      end
      chk("issues_before_reset", 32'(f_issues), 3);
      k_rst = 1; cycle(); k_rst = 0;
      chk_zero("mid_reset");
      run_frame(tbl[0]);

      for (int r = 0; r < 4; r++) run_frame(rnd_scen);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
